// File: rtl/serial_adder.sv
// serial_adder: bit-serial W-bit adder, LSB first, one full-adder slice per clock.
// A start accepted in IDLE latches the operands; W clocks later sum/cout are
// updated together with a one-cycle done pulse and held until the next result.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input (a - b via ~b and
// forced carry-in) and a registered signed-overflow output 'ovf'.
module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
  output logic         ovf,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         r_state;
  logic [W-1:0]   r_a_sh;
  logic [W-1:0]   r_b_sh;
  logic [W-2:0]   r_res_sh;
  logic           r_c;
  logic [CNT_W-1:0] r_cnt;

  logic           w_s;
  logic           w_c_next;
  logic [W-1:0]   w_res;
  logic           w_last;

  // Single full-adder slice on the current LSBs and the carry flop
  assign w_s      = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
  assign w_c_next = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
  // Result as it would look after this edge's shift; on the last bit it is complete
  assign w_res    = {w_s, r_res_sh};
  assign w_last   = (r_cnt == CNT_W'(W - 1));

  // Control FSM, serial datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh <= a;
`ifdef SERIAL_ADDER_SUB_EN
            // Subtract as a + ~b + 1; the caller's cin is irrelevant then
            r_b_sh <= sub ? ~b : b;
            r_c    <= sub | cin;
`else
            r_b_sh <= b;
            r_c    <= cin;
`endif
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sh   <= {1'b0, r_a_sh[W-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[W-1:1]};
          r_res_sh <= w_res[W-1:1];
          r_c      <= w_c_next;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            sum     <= w_res;
            cout    <= w_c_next;
`ifdef SERIAL_ADDER_SUB_EN
            // Carry into the MSB is the carry flop while the MSB is processed
            ovf     <= r_c ^ w_c_next;
`endif
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (W = 8) with a result scoreboard.
module tb_serial_adder;

  localparam int W = 8;

  typedef logic [W+1:0] exp_t;   // {ovf, cout, sum}

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
  logic         ovf;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  logic [W:0] hold;
  logic prev_done;

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ts);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   r;
    logic         ov;
    bb = ts ? ~tb_ : tb_;
    cc = ts ? 1'b1 : tc;
    r  = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, cc};
    ov = (ta[W-1] == bb[W-1]) && (r[W-1] != ta[W-1]);
    return {ov, r};
  endfunction

  // Drive a start that is accepted on the next edge (block assumed idle)
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    q.push_back(model(ta, tb_, tc, ts));
    check("busy_after_start", busy, 1);
  endtask

  // Count edges after acceptance until done; n0 edges already elapsed
  task automatic wait_done(input int n0);
    int n;
    n = n0;
    while (!done && n < 40) begin
      if (n > n0) check("busy_run", busy, 1);
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, W);
    check("busy_at_done", busy, 0);
  endtask

  // Scoreboard: compare on done, otherwise outputs must hold the last result
  always @(negedge clk) begin
    if (!rst_n) begin
      hold      = '0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_width", prev_done, 0);
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sum", sum, e[W-1:0]);
          check("cout", cout, e[W]);
`ifdef SERIAL_ADDER_SUB_EN
          check("ovf", ovf, e[W+1]);
`endif
        end
        hold = {cout, sum};
      end else begin
        check("hold", {cout, sum}, hold);
      end
      prev_done = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(posedge clk); #3; rst_n = 1'b1;

    // Basic additions
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0); wait_done(0);
    start_op(8'hFF, 8'h01, 1'b0, 1'b0); wait_done(0);
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0); wait_done(0);

    // Start and operand changes during busy are ignored
    start_op(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #4; a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hAA; cin = 1'b1;
    wait_done(3);

    // Start held across the done cycle: next op accepted with no idle cycle
    start_op(8'h01, 8'h02, 1'b0, 1'b0);
    #3; a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    wait_done(0);
    q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done(0);

    // Asynchronous reset mid-operation
    start_op(8'h80, 8'h80, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    void'(q.pop_back());
    @(posedge clk); #3; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle_after_rst", busy, 0);
    start_op(8'h12, 8'h34, 1'b1, 1'b0); wait_done(0);

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h10, 8'h01, 1'b0, 1'b1); wait_done(0);
    start_op(8'h80, 8'h01, 1'b1, 1'b1); wait_done(0);
    start_op(8'h7F, 8'h01, 1'b0, 1'b0); wait_done(0);
`endif

    repeat (3) @(posedge clk); #1;
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
